memwb_stage: RTL and testbench
==============================

// Module: memwb_stage
// PURPOSE
//  MEM->WB pipeline register plus load-data alignment/extension for the pipelined RV32I core.
//  Captures all five writeback result candidates from the Memory stage and presents them, registered, to the 5:1 result mux in Writeback.
//  Handles hazard-unit stall/flush and suppresses writes to x0.
// PARAMETERS
//  XLEN       32   datapath width of every result candidate
//  CNT_W      64   width of retire counter (only with RETIRE_CNT_EN)
// PORTS
//  clk         in   1      core clock; all state updates on rising edge
//  reset       in   1      synchronous, active-high reset
//  StallW      in   1      hazard unit: hold all W outputs
//  FlushW      in   1      hazard unit: insert bubble
//  ValidM      in   1      M-stage holds a real instruction
//  RegWriteM   in   1      M-stage instruction writes rd
//  RdM         in   5      destination register
//  ResultSrcM  in   3      result mux select (000 ALU, 001 load, 010 PC+4, 011 imm, 100 PC target)
//  Funct3M     in   3      load type
//  ALUResultM  in   XLEN   ALU result / load address
//  ReadDataM   in   XLEN   raw aligned word from data memory
//  PCPlus4M    in   XLEN   PC+4
//  ImmExtM     in   XLEN   extended immediate
//  PCTargetM   in   XLEN   branch/jump target
//  ValidW, RegWriteW, RdW, ResultSrcW  out  1/1/5/3  registered copies
//  ALUResultW, ReadDataW, PCPlus4W, ImmExtW, PCTargetW  out  XLEN  registered candidates (ReadDataW already extended)
//  RetireCntW  out  CNT_W  retired-instruction count (RETIRE_CNT_EN only)
// BEHAVIOUR
//  - Latency: 1 cycle M->W. Update priority per edge: reset > FlushW > StallW > load.
//  - reset: every output 0 (ResultSrcW=000, ValidW=0, RegWriteW=0, RdW=0, RetireCntW=0).
//  - FlushW: all outputs cleared exactly as reset, except RetireCntW holds.
//  - StallW (no flush): every output holds previous value.
//  - Load: capture M inputs; RegWriteW = RegWriteM & ValidM & (RdM != 0); x0 writes never leave this block.
//  - Flush and stall both high: flush wins.
//  - Load extension (combinational in M, before register), offset = ALUResultM[1:0]:
//      000 LB : byte[offset] sign-extended;   100 LBU: byte[offset] zero-extended
//      001 LH : half[ALUResultM[1]] sign-ext; 101 LHU: half[ALUResultM[1]] zero-ext
//      010 LW : word unchanged; ALUResultM[0] ignored for halfwords, [1:0] ignored for LW
//      011/110/111: raw word passed unchanged (no trap)
//    Extension is applied regardless of ResultSrcM; mux in W only selects it when 001.
//  - ResultSrcM 101-111 registered unchanged; interpretation belongs to the W mux.
//  - No handshake beyond stall/flush; block never back-pressures.
// CONFIGURATION
//  RETIRE_CNT_EN defined: RetireCntW present; increments by 1 on each edge where a load
//    occurs with ValidM=1 (not reset/flush/stall); wraps at 2^CNT_W; cleared only by reset.
//  RETIRE_CNT_EN undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  - Package riscv_pkg: ResultSrc encodings (RES_ALU..RES_PCTGT), load funct3 constants
//    (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU), XLEN default.
//  - Sub-module load_extend (Funct3, offset[1:0], word in -> XLEN out), purely combinational;
//    memwb_stage instantiates it once and owns all flops.
// TESTING
//  1 reset: assert reset 2 cycles with nonzero inputs -> all outputs 0; deassert -> next edge captures inputs.
//  2 extension: ReadDataM=32'h8070_F0A1, ALUResultM[1:0]=0..3, LB -> FFFF_FFA1, FFFF_FFF0, 0000_0070, FFFF_FF80;
//    LBU off 1 -> 0000_00F0; LH off 2 -> FFFF_8070; LHU off 0 -> 0000_F0A1; LW -> 8070_F0A1.
//  3 x0 gating: RegWriteM=1, ValidM=1, RdM=0 -> RegWriteW=0; RdM=5 -> RegWriteW=1, RdW=5.
//  4 stall: capture ALUResultM=1, then StallW=1 with ALUResultM=2 for 3 cycles -> ALUResultW stays 1; release -> 2.
//  5 flush: FlushW=1 with StallW=1, ValidM=1 -> ValidW=0, RegWriteW=0, ResultSrcW=000, all candidates 0.
//  6 RETIRE_CNT_EN: 10 valid loads, 2 stalls, 1 flush, 1 ValidM=0 cycle -> RetireCntW=10; reset -> 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32I pipeline: result-mux selects, load funct3 codes
// and the default datapath width.
package riscv_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] RES_ALU   = 3'b000;
  localparam logic [2:0] RES_LOAD  = 3'b001;
  localparam logic [2:0] RES_PC4   = 3'b010;
  localparam logic [2:0] RES_IMM   = 3'b011;
  localparam logic [2:0] RES_PCTGT = 3'b100;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// Combinational load-data alignment: selects the addressed byte/halfword of the raw
// memory word and sign- or zero-extends it according to the load funct3.
module load_extend
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [2:0]      Funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] word_in,
  output logic [XLEN-1:0] data_out
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_in[{offset, 3'b000} +: 8];
    half_sel = word_in[{offset[1], 4'b0000} +: 16];
    data_out = word_in;
    // Unsupported funct3 codes fall through with the raw word; no trap is raised here.
    case (Funct3)
      F3_LB:   data_out = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  data_out = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   data_out = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  data_out = {{(XLEN-16){1'b0}}, half_sel};
      default: data_out = word_in;
    endcase
  end

endmodule

// File: rtl/memwb_stage.sv
// MEM->WB pipeline register with load extension and x0 write suppression.
// Optional retired-instruction counter enabled by defining RETIRE_CNT_EN.
module memwb_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
`ifdef RETIRE_CNT_EN
  ,
  parameter int CNT_W = 64
`endif
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallW,
  input  logic            FlushW,
  input  logic            ValidM,
  input  logic            RegWriteM,
  input  logic [4:0]      RdM,
  input  logic [2:0]      ResultSrcM,
  input  logic [2:0]      Funct3M,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] ReadDataM,
  input  logic [XLEN-1:0] PCPlus4M,
  input  logic [XLEN-1:0] ImmExtM,
  input  logic [XLEN-1:0] PCTargetM,
  output logic            ValidW,
  output logic            RegWriteW,
  output logic [4:0]      RdW,
  output logic [2:0]      ResultSrcW,
  output logic [XLEN-1:0] ALUResultW,
  output logic [XLEN-1:0] ReadDataW,
  output logic [XLEN-1:0] PCPlus4W,
  output logic [XLEN-1:0] ImmExtW,
  output logic [XLEN-1:0] PCTargetW
`ifdef RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0] RetireCntW
`endif
);

  // Flow control: no valid/ready handshake. The stage never back-pressures; each
  // edge does reset, else FlushW (bubble), else StallW (hold), else capture M.
  logic [XLEN-1:0] load_data;
  logic            load_en;

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .Funct3   (Funct3M),
    .offset   (ALUResultM[1:0]),
    .word_in  (ReadDataM),
    .data_out (load_data)
  );

  assign load_en = !FlushW && !StallW;

  always_ff @(posedge clk) begin
    if (reset || FlushW) begin
      ValidW     <= 1'b0;
      RegWriteW  <= 1'b0;
      RdW        <= '0;
      ResultSrcW <= RES_ALU;
      ALUResultW <= '0;
      ReadDataW  <= '0;
      PCPlus4W   <= '0;
      ImmExtW    <= '0;
      PCTargetW  <= '0;
    end else if (load_en) begin
      ValidW     <= ValidM;
      // x0 is hardwired zero, so its writes are dropped before they reach the regfile.
      RegWriteW  <= RegWriteM && ValidM && (RdM != 5'd0);
      RdW        <= RdM;
      ResultSrcW <= ResultSrcM;
      ALUResultW <= ALUResultM;
      ReadDataW  <= load_data;
      PCPlus4W   <= PCPlus4M;
      ImmExtW    <= ImmExtM;
      PCTargetW  <= PCTargetM;
    end
  end

`ifdef RETIRE_CNT_EN
  // Counts only real instructions that actually advance into W; flush does not clear it.
  always_ff @(posedge clk) begin
    if (reset) begin
      RetireCntW <= '0;
    end else if (load_en && ValidM) begin
      RetireCntW <= RetireCntW + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_memwb_stage.sv
// Bench for memwb_stage: directed scenarios plus randomized cycles against a
// behavioural model of the stage's update rules and load extension.
module tb_memwb_stage;

  logic        clk = 1'b0;
  logic        reset, StallW, FlushW, ValidM, RegWriteM;
  logic [4:0]  RdM;
  logic [2:0]  ResultSrcM, Funct3M;
  logic [31:0] ALUResultM, ReadDataM, PCPlus4M, ImmExtM, PCTargetM;
  logic        ValidW, RegWriteW;
  logic [4:0]  RdW;
  logic [2:0]  ResultSrcW;
  logic [31:0] ALUResultW, ReadDataW, PCPlus4W, ImmExtW, PCTargetW;
`ifdef RETIRE_CNT_EN
  logic [63:0] RetireCntW;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        valid;
    logic        rw;
    logic [4:0]  rd;
    logic [2:0]  src;
    logic [31:0] alu, rdata, pc4, imm, tgt;
    logic [63:0] cnt;
  } model_t;
  model_t m;

  always #5 clk = ~clk;

  memwb_stage dut (
    .clk        (clk),
    .reset      (reset),
    .StallW     (StallW),
    .FlushW     (FlushW),
    .ValidM     (ValidM),
    .RegWriteM  (RegWriteM),
    .RdM        (RdM),
    .ResultSrcM (ResultSrcM),
    .Funct3M    (Funct3M),
    .ALUResultM (ALUResultM),
    .ReadDataM  (ReadDataM),
    .PCPlus4M   (PCPlus4M),
    .ImmExtM    (ImmExtM),
    .PCTargetM  (PCTargetM),
    .ValidW     (ValidW),
    .RegWriteW  (RegWriteW),
    .RdW        (RdW),
    .ResultSrcW (ResultSrcW),
    .ALUResultW (ALUResultW),
    .ReadDataW  (ReadDataW),
    .PCPlus4W   (PCPlus4W),
    .ImmExtW    (ImmExtW),
    .PCTargetW  (PCTargetW)
`ifdef RETIRE_CNT_EN
    ,
    .RetireCntW (RetireCntW)
`endif
  );

  // Reference load extension written with plain arithmetic on unsigned integers.
  function automatic logic [31:0] ref_ext(input logic [2:0] f3, input logic [31:0] addr,
                                          input logic [31:0] w);
    int unsigned off, b, h;
    off = addr % 4;
    b   = (w >> (8 * off)) % 256;
    h   = (w >> (16 * ((addr / 2) % 2))) % 65536;
    case (f3)
      3'd0:    return (b >= 128) ? (b + 32'hFFFF_FF00) : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? (h + 32'hFFFF_0000) : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  // One clock: the model sees the same inputs the DUT samples, then outputs settle.
  task automatic step();
    @(posedge clk);
    if (reset) begin
      m = '{default: '0};
    end else if (FlushW) begin
      m.valid = 0; m.rw = 0; m.rd = 0; m.src = 0;
      m.alu = 0; m.rdata = 0; m.pc4 = 0; m.imm = 0; m.tgt = 0;
    end else if (!StallW) begin
      m.valid = ValidM;
      m.rw    = RegWriteM && ValidM && (RdM != 0);
      m.rd    = RdM;
      m.src   = ResultSrcM;
      m.alu   = ALUResultM;
      m.rdata = ref_ext(Funct3M, ALUResultM, ReadDataM);
      m.pc4   = PCPlus4M;
      m.imm   = ImmExtM;
      m.tgt   = PCTargetM;
      if (ValidM) m.cnt = m.cnt + 1;
    end
    #1;
  endtask

  task automatic drive_idle();
    @(negedge clk);
    reset = 0; StallW = 0; FlushW = 0; ValidM = 1; RegWriteM = 1; RdM = 5'd1;
    ResultSrcM = 3'b000; Funct3M = 3'b010; ALUResultM = 32'h0; ReadDataM = 32'h0;
    PCPlus4M = 32'h4; ImmExtM = 32'h0; PCTargetM = 32'h0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1; StallW = 0; FlushW = 0; ValidM = 1; RegWriteM = 1; RdM = 5'd7;
    ResultSrcM = 3'b100; Funct3M = 3'b010; ALUResultM = 32'h1234_5678;
    ReadDataM = 32'hDEAD_BEEF; PCPlus4M = 32'h0000_1004; ImmExtM = 32'h0000_0ABC;
    PCTargetM = 32'h0000_2000;
    step();
    step();
    checks++;
    if ({ValidW, RegWriteW, RdW, ResultSrcW} !== 10'd0 ||
        {ALUResultW, ReadDataW, PCPlus4W, ImmExtW, PCTargetW} !== 160'd0) begin
      errors++;
      $display("FAIL reset_outputs: ctl=%b alu=%h rdata=%h pc4=%h imm=%h tgt=%h expected all 0",
               {ValidW, RegWriteW, RdW, ResultSrcW}, ALUResultW, ReadDataW, PCPlus4W,
               ImmExtW, PCTargetW);
    end
`ifdef RETIRE_CNT_EN
    checks++;
    if (RetireCntW !== 64'd0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d expected 0", RetireCntW);
    end
`endif
    @(negedge clk);
    reset = 0;
    step();
    checks++;
    if ({ValidW, RegWriteW, RdW, ResultSrcW} !== {1'b1, 1'b1, 5'd7, 3'b100} ||
        ALUResultW !== 32'h1234_5678 || ReadDataW !== 32'hDEAD_BEEF ||
        PCPlus4W !== 32'h0000_1004 || ImmExtW !== 32'h0000_0ABC || PCTargetW !== 32'h0000_2000) begin
      errors++;
      $display("FAIL reset_release_capture: ctl=%b alu=%h rdata=%h pc4=%h imm=%h tgt=%h",
               {ValidW, RegWriteW, RdW, ResultSrcW}, ALUResultW, ReadDataW, PCPlus4W,
               ImmExtW, PCTargetW);
    end
  endtask

  task automatic test_extension();
    logic [2:0]  f3s  [8] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
    logic [1:0]  offs [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd0, 2'd3};
    logic [31:0] exps [8] = '{32'hFFFF_FFA1, 32'hFFFF_FFF0, 32'h0000_0070, 32'hFFFF_FF80,
                              32'h0000_00F0, 32'hFFFF_8070, 32'h0000_F0A1, 32'h8070_F0A1};
    for (int i = 0; i < 8; i++) begin
      drive_idle();
      ResultSrcM = 3'b001;
      ReadDataM  = 32'h8070_F0A1;
      Funct3M    = f3s[i];
      ALUResultM = {30'h0000_1000, offs[i]};
      step();
      checks++;
      if (ReadDataW !== exps[i]) begin
        errors++;
        $display("FAIL ext_case%0d (f3=%0d off=%0d): got %h expected %h",
                 i, f3s[i], offs[i], ReadDataW, exps[i]);
      end
    end
    // Unsupported funct3 passes the raw word through.
    drive_idle();
    Funct3M = 3'b111; ReadDataM = 32'h8070_F0A1; ALUResultM = 32'h3;
    step();
    checks++;
    if (ReadDataW !== 32'h8070_F0A1) begin
      errors++;
      $display("FAIL ext_f3_111: got %h expected 8070f0a1", ReadDataW);
    end
  endtask

  task automatic test_x0_gating();
    drive_idle();
    RegWriteM = 1; ValidM = 1; RdM = 5'd0;
    step();
    checks++;
    if (RegWriteW !== 1'b0) begin
      errors++;
      $display("FAIL x0_gate: RegWriteW got %b expected 0", RegWriteW);
    end
    drive_idle();
    RdM = 5'd5;
    step();
    checks++;
    if (RegWriteW !== 1'b1 || RdW !== 5'd5) begin
      errors++;
      $display("FAIL x5_write: RegWriteW=%b RdW=%0d expected 1/5", RegWriteW, RdW);
    end
    drive_idle();
    RdM = 5'd5; ValidM = 0;
    step();
    checks++;
    if (RegWriteW !== 1'b0 || ValidW !== 1'b0) begin
      errors++;
      $display("FAIL invalid_write: RegWriteW=%b ValidW=%b expected 0/0", RegWriteW, ValidW);
    end
  endtask

  task automatic test_stall();
    drive_idle();
    ALUResultM = 32'd1;
    step();
    drive_idle();
    StallW = 1; ALUResultM = 32'd2; RdM = 5'd9;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (ALUResultW !== 32'd1 || RdW !== 5'd1) begin
        errors++;
        $display("FAIL stall_hold%0d: alu=%0d rd=%0d expected 1/1", i, ALUResultW, RdW);
      end
    end
    @(negedge clk);
    StallW = 0;
    step();
    checks++;
    if (ALUResultW !== 32'd2 || RdW !== 5'd9) begin
      errors++;
      $display("FAIL stall_release: alu=%0d rd=%0d expected 2/9", ALUResultW, RdW);
    end
  endtask

  task automatic test_flush();
    drive_idle();
    ALUResultM = 32'hAAAA_5555; ReadDataM = 32'h1111_2222; PCPlus4M = 32'h44; ImmExtM = 32'h55;
    PCTargetM = 32'h66; ResultSrcM = 3'b011;
    step();
    @(negedge clk);
    FlushW = 1; StallW = 1;
    step();
    checks++;
    if ({ValidW, RegWriteW, RdW, ResultSrcW} !== 10'd0 ||
        {ALUResultW, ReadDataW, PCPlus4W, ImmExtW, PCTargetW} !== 160'd0) begin
      errors++;
      $display("FAIL flush_over_stall: ctl=%b alu=%h rdata=%h pc4=%h imm=%h tgt=%h",
               {ValidW, RegWriteW, RdW, ResultSrcW}, ALUResultW, ReadDataW, PCPlus4W,
               ImmExtW, PCTargetW);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      reset      = ($urandom_range(0, 49) == 0);
      FlushW     = ($urandom_range(0, 15) == 0);
      StallW     = ($urandom_range(0, 7) == 0);
      ValidM     = ($urandom_range(0, 3) != 0);
      RegWriteM  = $urandom_range(0, 1);
      RdM        = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      ResultSrcM = 3'($urandom);
      Funct3M    = 3'($urandom);
      ALUResultM = $urandom; ReadDataM = $urandom; PCPlus4M = $urandom;
      ImmExtM    = $urandom; PCTargetM = $urandom;
      step();
      checks++;
      if ({ValidW, RegWriteW, RdW, ResultSrcW} !== {m.valid, m.rw, m.rd, m.src}) begin
        errors++;
        $display("FAIL rand%0d_ctl: got %b expected %b", i,
                 {ValidW, RegWriteW, RdW, ResultSrcW}, {m.valid, m.rw, m.rd, m.src});
      end
      checks++;
      if (ReadDataW !== m.rdata) begin
        errors++;
        $display("FAIL rand%0d_rdata: got %h expected %h", i, ReadDataW, m.rdata);
      end
      checks++;
      if ({ALUResultW, PCPlus4W, ImmExtW, PCTargetW} !== {m.alu, m.pc4, m.imm, m.tgt}) begin
        errors++;
        $display("FAIL rand%0d_cand: got %h %h %h %h expected %h %h %h %h", i, ALUResultW,
                 PCPlus4W, ImmExtW, PCTargetW, m.alu, m.pc4, m.imm, m.tgt);
      end
`ifdef RETIRE_CNT_EN
      checks++;
      if (RetireCntW !== m.cnt) begin
        errors++;
        $display("FAIL rand%0d_cnt: got %0d expected %0d", i, RetireCntW, m.cnt);
      end
`endif
    end
  endtask

`ifdef RETIRE_CNT_EN
  task automatic test_retire_cnt();
    @(negedge clk);
    reset = 1;
    step();
    for (int i = 0; i < 14; i++) begin
      drive_idle();
      if (i == 3 || i == 8) StallW = 1;
      if (i == 5) FlushW = 1;
      if (i == 11) ValidM = 0;
      step();
    end
    checks++;
    if (RetireCntW !== 64'd10) begin
      errors++;
      $display("FAIL retire_count: got %0d expected 10", RetireCntW);
    end
    @(negedge clk);
    reset = 1;
    step();
    checks++;
    if (RetireCntW !== 64'd0) begin
      errors++;
      $display("FAIL retire_reset: got %0d expected 0", RetireCntW);
    end
    @(negedge clk);
    reset = 0;
  endtask
`endif

  initial begin
    m = '{default: '0};
    reset = 1; StallW = 0; FlushW = 0; ValidM = 0; RegWriteM = 0; RdM = 0;
    ResultSrcM = 0; Funct3M = 0; ALUResultM = 0; ReadDataM = 0; PCPlus4M = 0;
    ImmExtM = 0; PCTargetM = 0;
    test_reset();
    test_extension();
    test_x0_gating();
    test_stall();
    test_flush();
    test_random();
`ifdef RETIRE_CNT_EN
    test_retire_cnt();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
